// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter
// and any later arbiter that reuses rr_pick.
//   MAX_REQ     : largest supported requester count
//   GNT_W       : width of a requester index (gnt_id, rr_ptr)
//   arb_state_t : sequencer state encoding
//   rr_next()   : round-robin successor of an index, wrapping at n-1
package uart_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int GNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_CKSUM = 3'd4
  } arb_state_t;

  function automatic logic [GNT_W-1:0] rr_next(input logic [GNT_W-1:0] id,
                                               input int n);
    if (int'(id) >= n - 1) return '0;
    return id + GNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: byte-lane and serializer handshake bundle for uart_tx_arb.
//   req_vld  : lane i holds a byte
//   req_data : byte on lane i (packed, lane i = req_data[i])
//   req_last : byte on lane i ends its packet
//   req_rdy  : byte on lane i accepted this cycle (one-hot or zero)
//   trmt     : start pulse to UART_tx
//   tx_data  : byte to UART_tx, valid while trmt = 1
//   tx_done  : UART_tx completion flag (level)
// master = arbiter side, slave = requesters + UART side.
interface uart_tx_arb_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ-1:0][7:0]  req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_rdy;
  logic                   trmt;
  logic [7:0]             tx_data;
  logic                   tx_done;

  modport master (
    input  req_vld, req_data, req_last, tx_done,
    output req_rdy, trmt, tx_data
  );

  modport slave (
    output req_vld, req_data, req_last, tx_done,
    input  req_rdy, trmt, tx_data
  );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   i_req : request vector
//   i_ptr : index with highest priority this round (must be < N_REQ)
//   o_idx : first requesting index at or after i_ptr, wrapping at N_REQ-1
//   o_any : at least one request present
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GNT_W-1:0] i_ptr,
  output logic [GNT_W-1:0] o_idx,
  output logic             o_any
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Walk offsets from farthest to nearest so the nearest hit to i_ptr
  // is the last assignment and therefore wins.
  always_comb begin
    int                 w_pos;
    logic [IDX_W-1:0]   w_cand;
    o_idx  = '0;
    w_pos  = 0;
    w_cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_pos = int'(i_ptr) + i;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      w_cand = IDX_W'(w_pos);
      if (i_req[w_cand]) o_idx = GNT_W'(w_pos);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-level round-robin arbiter sharing one UART_tx between
// N_REQ byte-stream requesters. The grant is held until the owner's last
// byte has shifted out, so packets never interleave on the wire.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : requester lanes + UART_tx handshake (master modport)
//   o_busy       : a packet is in progress
//   o_gnt_id     : current owner, valid while o_busy
//   o_pkt_done   : one-cycle pulse once the owner's packet is fully sent
// Parameters: N_REQ (2..8), GAP_CLKS (idle clocks after each tx_done).
// Build option: UART_ARB_CKSUM_EN appends a two's-complement checksum byte
// after every packet so that all bytes on the wire sum to 0x00.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int GAP_CLKS = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_arb_if.master     bus,
  output logic              o_busy,
  output logic [GNT_W-1:0]  o_gnt_id,
  output logic              o_pkt_done
);
  localparam int          IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] GAP_LAST = (GAP_CLKS > 0) ? 16'(GAP_CLKS - 1) : 16'd0;

  arb_state_t        r_state;
  logic [GNT_W-1:0]  r_owner;
  logic [GNT_W-1:0]  r_rr_ptr;
  logic              r_last;
  logic [15:0]       r_gap;
  logic              r_busy;
  logic              r_pkt_done;
`ifdef UART_ARB_CKSUM_EN
  logic [7:0]        r_sum;
  logic              r_ck_sent;
`endif

  logic [GNT_W-1:0]  w_win;
  logic              w_any;
  logic [IDX_W-1:0]  w_oidx;
  logic              w_own_vld;
  logic [7:0]        w_own_data;
  logic              w_own_last;
  logic              w_byte_end;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req (bus.req_vld),
    .i_ptr (r_rr_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_oidx     = r_owner[IDX_W-1:0];
  assign w_own_vld  = bus.req_vld[w_oidx];
  assign w_own_data = bus.req_data[w_oidx];
  assign w_own_last = bus.req_last[w_oidx];

  // A byte slot ends either on tx_done (no gap) or on the last gap count.
  assign w_byte_end = ((r_state == ST_WAIT) && bus.tx_done && (GAP_CLKS == 0)) ||
                      ((r_state == ST_GAP)  && (r_gap == GAP_LAST));

  // Strobes to the serializer and requesters are combinational so the
  // accept, the start pulse and the byte all land in the same cycle.
  always_comb begin
    bus.trmt    = 1'b0;
    bus.tx_data = 8'h00;
    bus.req_rdy = '0;
    if (r_state == ST_SEND && w_own_vld) begin
      bus.trmt            = 1'b1;
      bus.tx_data         = w_own_data;
      bus.req_rdy[w_oidx] = 1'b1;
    end
`ifdef UART_ARB_CKSUM_EN
    if (r_state == ST_CKSUM) begin
      bus.trmt    = 1'b1;
      bus.tx_data = (~r_sum) + 8'd1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_last     <= 1'b0;
      r_gap      <= '0;
      r_busy     <= 1'b0;
      r_pkt_done <= 1'b0;
`ifdef UART_ARB_CKSUM_EN
      r_sum      <= '0;
      r_ck_sent  <= 1'b0;
`endif
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_busy  <= 1'b1;
            r_state <= ST_SEND;
`ifdef UART_ARB_CKSUM_EN
            r_sum     <= '0;
            r_ck_sent <= 1'b0;
`endif
          end
        end
        // Owner keeps the grant through stalls of any length.
        ST_SEND: begin
          if (w_own_vld) begin
            r_last  <= w_own_last;
            r_state <= ST_WAIT;
`ifdef UART_ARB_CKSUM_EN
            r_sum   <= r_sum + w_own_data;
`endif
          end
        end
        ST_WAIT: begin
          if (bus.tx_done && (GAP_CLKS != 0)) begin
            r_gap   <= '0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap != GAP_LAST) r_gap <= r_gap + 16'd1;
        end
`ifdef UART_ARB_CKSUM_EN
        ST_CKSUM: begin
          r_ck_sent <= 1'b1;
          r_state   <= ST_WAIT;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase

      // After-byte decision overrides the per-state defaults above.
      if (w_byte_end) begin
        r_gap <= '0;
        if (!r_last) begin
          r_state <= ST_SEND;
        end
`ifdef UART_ARB_CKSUM_EN
        else if (!r_ck_sent) begin
          r_state <= ST_CKSUM;
        end
`endif
        else begin
          r_pkt_done <= 1'b1;
          r_rr_ptr   <= rr_next(r_owner, N_REQ);
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_gnt_id   = r_owner;
  assign o_pkt_done = r_pkt_done;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb. Instance G[0] has
// N_REQ=3, GAP_CLKS=0; instance G[1] has N_REQ=3, GAP_CLKS=16. Expected
// bytes/owners/spacing are queued by the stimulus; per-instance monitors
// pop and compare whenever trmt or pkt_done is seen. Honors
// UART_ARB_CKSUM_EN by expecting the hand-computed checksum bytes.
module tb_uart_tx_arb;

  typedef struct {
    logic [7:0] d;
    int         g;
    int         sp;
    bit         ck;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc  = 0;
  int   nchk = 0;
  int   nerr = 0;

  exp_t       eq[2][$];
  int         pq[2][$];
  logic [8:0] lq[2][3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : G
    localparam int GAP = (g == 0) ? 0 : 16;
    logic [2:0]      vld = '0;
    logic [2:0]      lst = '0;
    logic [2:0][7:0] dat = '0;
    logic [2:0]      rdy;
    logic [2:0]      gnt;
    logic [7:0]      txd;
    logic            trmt, busy, pkd;
    logic            done = 1'b0;
    int              ucnt = 0;

    uart_tx_arb_if #(.N_REQ(3)) bus ();
    assign bus.req_vld  = vld;
    assign bus.req_data = dat;
    assign bus.req_last = lst;
    assign bus.tx_done  = done;
    assign rdy  = bus.req_rdy;
    assign trmt = bus.trmt;
    assign txd  = bus.tx_data;

    uart_tx_arb #(.N_REQ(3), .GAP_CLKS(GAP)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .bus        (bus.master),
      .o_busy     (busy),
      .o_gnt_id   (gnt),
      .o_pkt_done (pkd)
    );

    // UART_tx stand-in: tx_done rises 4 clocks after trmt, held until next trmt.
    always @(posedge clk) begin
      if (rst) begin
        done <= 1'b0;
        ucnt <= 0;
      end else if (trmt) begin
        done <= 1'b0;
        ucnt <= 4;
      end else if (ucnt != 0) begin
        ucnt <= ucnt - 1;
        if (ucnt == 1) done <= 1'b1;
      end
    end

    // Requester lanes: present queue heads at negedge, pop on accept.
    initial forever begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        if (lq[g][l].size() > 0) begin
          vld[l] = 1'b1;
          dat[l] = lq[g][l][0][7:0];
          lst[l] = lq[g][l][0][8];
        end else begin
          vld[l] = 1'b0;
          dat[l] = 8'h00;
          lst[l] = 1'b0;
        end
      end
      #4;
      for (int l = 0; l < 3; l++)
        if (rdy[l] && lq[g][l].size() > 0) void'(lq[g][l].pop_front());
    end

    // Monitor: sampled just before each posedge.
    initial begin
      int   dcyc;
      int   pg;
      logic pdone;
      exp_t e;
      dcyc  = 0;
      pdone = 1'b0;
      forever begin
        @(negedge clk);
        #4;
        if (rst) begin
          pdone = 1'b0;
        end else begin
          if (done && !pdone) dcyc = cyc;
          pdone = done;
          if (trmt) begin
            if (eq[g].size() == 0) chk($sformatf("g%0d_extra_trmt", g), int'(txd), 256);
            else begin
              e = eq[g].pop_front();
              chk($sformatf("g%0d_tx_data", g), int'(txd), int'(e.d));
              chk($sformatf("g%0d_gnt_at_trmt", g), int'(gnt), e.g);
              chk($sformatf("g%0d_busy_at_trmt", g), int'(busy), 1);
              chk($sformatf("g%0d_rdy_at_trmt", g), int'(rdy), e.ck ? 0 : (1 << e.g));
              if (e.sp >= 0) chk($sformatf("g%0d_byte_spacing", g), cyc - dcyc, e.sp);
            end
          end else if (rdy != 3'b000) begin
            chk($sformatf("g%0d_rdy_without_trmt", g), int'(rdy), 0);
          end
          if (pkd) begin
            if (pq[g].size() == 0) chk($sformatf("g%0d_extra_pkt_done", g), int'(gnt), 99);
            else begin
              pg = pq[g].pop_front();
              chk($sformatf("g%0d_pkt_done_gnt", g), int'(gnt), pg);
              chk($sformatf("g%0d_pkt_done_busy", g), int'(busy), 0);
              chk($sformatf("g%0d_pkt_done_lat", g), cyc - dcyc, 1 + GAP);
            end
          end
        end
      end
    end
  end

  task automatic ex(input int g, input logic [7:0] d, input int gn, input int sp);
    exp_t e;
    e = '{d, gn, sp, 1'b0};
    eq[g].push_back(e);
  endtask

  // Packet end: checksum byte (when enabled) follows one tx_done + gap later.
  task automatic ex_end(input int g, input int gn, input logic [7:0] ck);
    exp_t e;
    e = '{ck, gn, (g == 0) ? 1 : 17, 1'b1};
`ifdef UART_ARB_CKSUM_EN
    eq[g].push_back(e);
`endif
    pq[g].push_back(gn);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_g0_trmt"}, int'(G[0].trmt), 0);
    chk({tag, "_g0_txd"},  int'(G[0].txd),  0);
    chk({tag, "_g0_rdy"},  int'(G[0].rdy),  0);
    chk({tag, "_g0_busy"}, int'(G[0].busy), 0);
    chk({tag, "_g0_gnt"},  int'(G[0].gnt),  0);
    chk({tag, "_g0_pkd"},  int'(G[0].pkd),  0);
    chk({tag, "_g1_trmt"}, int'(G[1].trmt), 0);
    chk({tag, "_g1_busy"}, int'(G[1].busy), 0);
    chk({tag, "_g1_gnt"},  int'(G[1].gnt),  0);
    chk({tag, "_g1_pkd"},  int'(G[1].pkd),  0);
  endtask

  task automatic do_rst(input string tag);
    @(negedge clk);
    #4;
    rst = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int l = 0; l < 3; l++) lq[g][l].delete();
    @(negedge clk);
    #4;
    rst_check(tag);
    rst = 1'b0;
  endtask

  task automatic drain(input int g, input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (eq[g].size() == 0 && pq[g].size() == 0 && lq[g][0].size() == 0 &&
          lq[g][1].size() == 0 && lq[g][2].size() == 0) break;
      @(negedge clk);
    end
    chk({tag, "_drain_timeout"}, int'(i < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int i;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #4;
    rst_check("por");
    rst = 1'b0;

    // Single-byte packet.
    lq[0][0].push_back({1'b1, 8'hA5});
    ex(0, 8'hA5, 0, -1); ex_end(0, 0, 8'h5B);
    drain(0, "single");

    // Non-interleaving: 3-byte packet on lane 0 while lane 1 waits.
    do_rst("r2");
    lq[0][0].push_back({1'b0, 8'h01});
    lq[0][0].push_back({1'b0, 8'h02});
    lq[0][0].push_back({1'b1, 8'h03});
    lq[0][1].push_back({1'b1, 8'h10});
    ex(0, 8'h01, 0, -1); ex(0, 8'h02, 0, 1); ex(0, 8'h03, 0, 1); ex_end(0, 0, 8'hFA);
    ex(0, 8'h10, 1, 2);  ex_end(0, 1, 8'hF0);
    drain(0, "nointerleave");

    // Round-robin fairness across three busy lanes.
    do_rst("r3");
    lq[0][0].push_back({1'b1, 8'hA0}); lq[0][0].push_back({1'b1, 8'hA1});
    lq[0][1].push_back({1'b1, 8'hB0}); lq[0][1].push_back({1'b1, 8'hB1});
    lq[0][2].push_back({1'b1, 8'hC0}); lq[0][2].push_back({1'b1, 8'hC1});
    ex(0, 8'hA0, 0, -1); ex_end(0, 0, 8'h60);
    ex(0, 8'hB0, 1, 2);  ex_end(0, 1, 8'h50);
    ex(0, 8'hC0, 2, 2);  ex_end(0, 2, 8'h40);
    ex(0, 8'hA1, 0, 2);  ex_end(0, 0, 8'h5F);
    ex(0, 8'hB1, 1, 2);  ex_end(0, 1, 8'h4F);
    ex(0, 8'hC1, 2, 2);  ex_end(0, 2, 8'h3F);
    drain(0, "rr");

    // Owner stall: lane 0 goes quiet for 500 clocks mid-packet.
    do_rst("r4");
    lq[0][0].push_back({1'b0, 8'h21});
    lq[0][1].push_back({1'b1, 8'h31});
    ex(0, 8'h21, 0, -1); ex(0, 8'h22, 0, -1); ex_end(0, 0, 8'hBD);
    ex(0, 8'h31, 1, 2);  ex_end(0, 1, 8'hCF);
    for (i = 0; i < 200 && lq[0][0].size() != 0; i++) @(negedge clk);
    chk("stall_first_byte_taken", int'(lq[0][0].size()), 0);
    repeat (500) @(negedge clk);
    #4;
    chk("stall_busy", int'(G[0].busy), 1);
    chk("stall_gnt", int'(G[0].gnt), 0);
    chk("stall_lane1_pending", int'(lq[0][1].size()), 1);
    lq[0][0].push_back({1'b1, 8'h22});
    drain(0, "stall");

    // Reset mid-packet: move rr_ptr to 2, abandon lane 2's packet in WAIT.
    do_rst("r5");
    lq[0][1].push_back({1'b1, 8'h3F});
    ex(0, 8'h3F, 1, -1); ex_end(0, 1, 8'hC1);
    drain(0, "pre_mid");
    lq[0][2].push_back({1'b0, 8'h41});
    lq[0][2].push_back({1'b0, 8'h42});
    lq[0][2].push_back({1'b1, 8'h43});
    ex(0, 8'h41, 2, -1); ex(0, 8'h42, 2, 1);
    for (i = 0; i < 200 && eq[0].size() != 0; i++) @(negedge clk);
    chk("mid_second_byte_sent", int'(eq[0].size()), 0);
    do_rst("midrst");
    lq[0][0].push_back({1'b1, 8'h61});
    lq[0][1].push_back({1'b1, 8'h71});
    lq[0][2].push_back({1'b1, 8'h81});
    ex(0, 8'h61, 0, -1); ex_end(0, 0, 8'h9F);
    ex(0, 8'h71, 1, 2);  ex_end(0, 1, 8'h8F);
    ex(0, 8'h81, 2, 2);  ex_end(0, 2, 8'h7F);
    drain(0, "post_mid");

    // Gap (16 clocks) and optional checksum on the second instance.
    lq[1][0].push_back({1'b0, 8'h12});
    lq[1][0].push_back({1'b1, 8'h34});
    ex(1, 8'h12, 0, -1); ex(1, 8'h34, 0, 17); ex_end(1, 0, 8'hBA);
    drain(1, "gap");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter and sequencer that shares one `UART_tx` serializer between `N_REQ` byte-stream requesters. It sits between the requesters (telemetry, command responses, debug) and the transmitter. It drives `trmt`/`tx_data`, paces on `tx_done`, and holds the grant until the owner's last byte, so packets from different requesters never interleave on `TX`.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `GAP_CLKS`, default 0: idle clocks inserted after each byte's `tx_done`, before the next `trmt`. Range 0..65535.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_vld`  in  N_REQ  requester i has a byte on its lane.
- `req_data`  in  8*N_REQ  byte lane i is `req_data[8i+7:8i]`.
- `req_last`  in  N_REQ  the byte on lane i is the last byte of its packet.
- `req_rdy`  out  N_REQ  byte on lane i is accepted this cycle (one-cycle pulse).
- `trmt`  out  1  start pulse to `UART_tx`.
- `tx_data`  out  8  byte to `UART_tx`, valid while `trmt` = 1.
- `tx_done`  in  1  `UART_tx` completion flag, level.
- `busy`  out  1  a packet is in progress.
- `gnt_id`  out  3  current owner index, valid while `busy` = 1.
- `pkt_done`  out  1  one-cycle pulse when the owner's packet, including its checksum if enabled, has fully shifted out.

## Operation
- States: IDLE, SEND, WAIT, GAP, CKSUM.
- **IDLE:**
  - If any `req_vld` is set, pick a winner by round-robin. The search starts at `rr_ptr` and wraps at `N_REQ`-1 to 0.
  - Register the winner as owner, clear `sum`, go to SEND.
  - Requests from non-owners are ignored until the owner releases.
- **SEND:**
  - If `req_vld[owner]` = 1: assert `trmt`, `tx_data = lane[owner]` and `req_rdy[owner]`, all in the same cycle.
  - In that cycle, also register `last = req_last[owner]` and update `sum += byte` (mod 256). Then go to WAIT.
  - If `req_vld[owner]` = 0: stay in SEND. The owner keeps the grant, so mid-packet stalls are legal and unbounded.
- **WAIT:**
  - On `tx_done` = 1, go to GAP if `GAP_CLKS` > 0; otherwise go straight to the after-byte decision.
- **GAP:** a 16-bit counter counts `GAP_CLKS` clocks, then the after-byte decision is taken.
- **After-byte decision:**
  - If `last` = 0: go to SEND.
  - If `last` = 1 and the checksum is enabled and not yet sent: go to CKSUM.
  - Otherwise:
    - pulse `pkt_done`;
    - set `rr_ptr = (owner+1) mod N_REQ`;
    - drop `busy`;
    - go to IDLE.
- **CKSUM:** assert `trmt` with `tx_data = (~sum)+1`, mark the checksum as sent, go to WAIT.
- **Outputs:**
  - `trmt`, `tx_data` and `req_rdy` are combinational from the state and owner lane.
  - `busy`, `gnt_id`, `pkt_done` and `rr_ptr` are registered.
  - `req_rdy` is one-hot or zero. `req_rdy[owner] == trmt` except in CKSUM, where `req_rdy` = 0.
- **Reset:**
  - Reset values: state IDLE, `trmt` 0, `tx_data` 0x00, `req_rdy` 0, `busy` 0, `gnt_id` 0, `pkt_done` 0, `rr_ptr` 0, `sum` 0, gap counter 0.
  - Reset mid-packet abandons the packet with no `pkt_done`. The UART is reset by its own domain.

## Timing
- Arbitration cycle k in IDLE; earliest `trmt` at k+1 (SEND).
- The UART clears `tx_done` on the edge that samples `trmt`, so WAIT never sees a stale 1. `tx_done` is not examined outside WAIT.
- Byte-to-byte spacing with a continuously valid requester:
  - `tx_done` seen at cycle t;
  - `trmt` at t+1 when `GAP_CLKS` = 0;
  - `trmt` at t+1+`GAP_CLKS` otherwise.
- `pkt_done` asserts the cycle after the final `tx_done` (or after the final GAP count). IDLE can arbitrate again in that same cycle.
- The round-robin pointer advances only on packet completion, never on a stall.

## Configuration
- `UART_ARB_CKSUM_EN`
  - **Defined:** CKSUM state present. A two's-complement checksum byte is appended after every packet, so the bytes on the wire sum to 0x00 mod 256.
  - **Undefined:** CKSUM state and `sum` register are compiled out. `pkt_done` follows the last requester byte.

## Structure
- Shared package `uart_arb_pkg`: state enum `arb_state_t`, `MAX_REQ` = 8, `GNT_W` = 3.
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs are the request vector and `rr_ptr`; outputs are the winner index and `any`. It is reused by later arbiters.

## Test plan
- **Single-byte packet:** requester 0 sends 0xA5 with `last`, `GAP_CLKS`=0, checksum off.
  - One `trmt` with 0xA5.
  - `pkt_done` the cycle after `tx_done`.
  - `busy` 1→0.
- **Non-interleaving:** req0 sends a 3-byte packet 0x01,0x02,0x03 and req1 sends 0x10, both valid at the same cycle.
  - `TX` carries 01,02,03 then 10.
  - `gnt_id` = 0 then 1.
- **Round-robin fairness:** `N_REQ`=3, all three continuously request 1-byte packets. Grant order is 0,1,2,0,1,2.
- **Owner stall:** req0 drops `req_vld` for 500 clocks between bytes while req1 requests.
  - req1 is not granted until req0's `last` byte completes.
- **Gap and checksum:** `GAP_CLKS`=16, `UART_ARB_CKSUM_EN` defined, packet 0x12,0x34.
  - Bytes 12,34,BA on the wire.
  - ≥16 idle clocks between each `tx_done` and the next `trmt`.
- **Reset mid-packet:** assert `rst` during WAIT of byte 2.
  - All outputs return to reset values next cycle, with no `pkt_done`.
  - The next grant goes to requester 0.
